// File: rtl/mux_4_1_rr_feeder.sv
// Four-channel round-robin feeder for a 4:1 mux: per-channel holding registers,
// registered grant index and a single output handshake. Optional macro MUX_RR_FEED_CNT_EN adds acc_cnt.
module mux_4_1_rr_feeder #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    output logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ready
`ifdef MUX_RR_FEED_CNT_EN
    ,
    output logic [15:0]  acc_cnt
`endif
);

    logic [3:0]   full_r;
    logic [W-1:0] d_r [4];
    logic [1:0]   sel_r;
    logic [1:0]   last_r;
    logic         out_valid_r;

    logic [W-1:0] in_data_s [4];
    logic [3:0]   capture_s;
    logic         drain_s;
    logic         free_s;
    logic [3:0]   drain_mask_s;
    logic [3:0]   cand_s;
    logic [3:0]   full_nxt_s;
    logic [1:0]   probe_s;
    logic [1:0]   hit_idx_s;
    logic         hit_found_s;

    assign in_data_s[0] = in_data0;
    assign in_data_s[1] = in_data1;
    assign in_data_s[2] = in_data2;
    assign in_data_s[3] = in_data3;

    assign in_ready  = ~full_r;
    assign d0        = d_r[0];
    assign d1        = d_r[1];
    assign d2        = d_r[2];
    assign d3        = d_r[3];
    assign sel       = sel_r;
    assign out_valid = out_valid_r;

    // Handshake decode and next occupancy; a drained channel is never captured at the same edge.
    always_comb begin
        capture_s    = in_valid & ~full_r;
        drain_s      = out_valid_r & out_ready;
        free_s       = ~out_valid_r | out_ready;
        drain_mask_s = 4'b0000;
        if (drain_s) begin
            drain_mask_s = 4'b0001 << sel_r;
        end else begin
            drain_mask_s = 4'b0000;
        end
        cand_s     = full_r & ~drain_mask_s;
        full_nxt_s = (full_r & ~drain_mask_s) | capture_s;
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        hit_found_s = 1'b0;
        hit_idx_s   = last_r;
        probe_s     = last_r;
        for (int k = 1; k < 5; k++) begin
            probe_s = last_r + k[1:0];
            if (!hit_found_s && cand_s[probe_s]) begin
                hit_found_s = 1'b1;
                hit_idx_s   = probe_s;
            end else begin
                hit_found_s = hit_found_s;
            end
        end
    end

    // Occupancy flags and holding registers; data changes only on capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                d_r[i] <= {W{1'b0}};
            end
        end else begin
            full_r <= full_nxt_s;
            for (int i = 0; i < 4; i++) begin
                if (capture_s[i]) begin
                    d_r[i] <= in_data_s[i];
                end
            end
        end
    end

    // Grant register: re-arbitrate only when the output slot is free, otherwise hold the stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_r       <= 2'd0;
            last_r      <= 2'd3;
            out_valid_r <= 1'b0;
        end else if (free_s) begin
            if (hit_found_s) begin
                sel_r       <= hit_idx_s;
                last_r      <= hit_idx_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef MUX_RR_FEED_CNT_EN
    logic [15:0] acc_cnt_r;

    // Accepted-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_cnt_r <= 16'd0;
        end else if (drain_s) begin
            acc_cnt_r <= acc_cnt_r + 16'd1;
        end
    end

    assign acc_cnt = acc_cnt_r;
`endif

endmodule

// File: tb/tb_mux_4_1_rr_feeder.sv
// Directed bench for mux_4_1_rr_feeder: vector table plus hand-written sequences
// for backpressure, fairness, mid-operation reset and (with MUX_RR_FEED_CNT_EN) counter wrap.
module tb_mux_4_1_rr_feeder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [W-1:0] d0, d1, d2, d3;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
`ifdef MUX_RR_FEED_CNT_EN
    logic [15:0]  acc_cnt;
`endif

    int checks;
    int failures;

    mux_4_1_rr_feeder #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_RR_FEED_CNT_EN
        ,
        .acc_cnt  (acc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4:1 mux as seen by the consumer.
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = {W{1'b0}};
        endcase
    end

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic [15:0] data;   // {ch3, ch2, ch1, ch0}
        logic        ordy;
        logic        e_ov;
        logic [1:0]  e_sel;
        logic [3:0]  e_y;
        logic [3:0]  e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] iv, input logic [15:0] data, input logic ordy,
                       input logic e_ov, input logic [1:0] e_sel, input logic [3:0] e_y, input logic [3:0] e_ir);
        vec_t v;
        v.rst = r; v.iv = iv; v.data = data; v.ordy = ordy;
        v.e_ov = e_ov; v.e_sel = e_sel; v.e_y = e_y; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] iv, input logic [15:0] data, input logic ordy);
        rst = r; in_valid = iv; out_ready = ordy;
        in_data0 = data[3:0]; in_data1 = data[7:4]; in_data2 = data[11:8]; in_data3 = data[15:12];
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 16'h0000, 1'b0);
        step();
        step();
    endtask

    initial begin
        int cnt [4];
        int repeats;
        int grants;
        logic [1:0] prev;
        checks = 0;
        failures = 0;
        drive(1'b0, 4'h0, 16'h0000, 1'b0);

        // rst, in_valid, data, out_ready -> out_valid, sel, y, in_ready (after the edge)
        add(1'b0, 4'hF, 16'h0000, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF);
        add(1'b0, 4'hF, 16'h0000, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF);
        add(1'b1, 4'h4, 16'h0A00, 1'b1, 1'b0, 2'd0, 4'h0, 4'hB);
        add(1'b1, 4'h0, 16'h0000, 1'b0, 1'b1, 2'd2, 4'hA, 4'hB);
        add(1'b1, 4'h0, 16'h0000, 1'b1, 1'b0, 2'd2, 4'hA, 4'hF);
        add(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF);
        add(1'b1, 4'hF, 16'h4321, 1'b1, 1'b0, 2'd0, 4'h1, 4'h0);
        add(1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 2'd0, 4'h1, 4'h0);
        add(1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 2'd1, 4'h2, 4'h1);
        add(1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 2'd2, 4'h3, 4'h3);
        add(1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 2'd3, 4'h4, 4'h7);
        add(1'b1, 4'h0, 16'h0000, 1'b1, 1'b0, 2'd3, 4'h4, 4'hF);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].data, vecs[i].ordy);
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_sel", i),       32'(sel),       32'(vecs[i].e_sel));
            chk($sformatf("vec%0d_y", i),         32'(y),         32'(vecs[i].e_y));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
        end

        // Backpressure: granted word must hold and block its own channel.
        do_reset();
        drive(1'b1, 4'h2, 16'h0050, 1'b0);
        step();
        drive(1'b1, 4'h2, 16'h0090, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_sel", i),       32'(sel),       32'd1);
            chk($sformatf("bp%0d_d1", i),        32'(d1),        32'h5);
            chk($sformatf("bp%0d_in_ready1", i), 32'(in_ready[1]), 32'd0);
            step();
        end
        chk("bp_y_before_accept", 32'(y), 32'h5);
        out_ready = 1'b1;
        step();
        chk("bp_drained_ready", 32'(in_ready[1]), 32'd1);
        chk("bp_drained_ov", 32'(out_valid), 32'd0);
        step();
        chk("bp_refill_d1", 32'(d1), 32'h9);
        in_valid = 4'h0;
        step();
        chk("bp_regrant_ov", 32'(out_valid), 32'd1);
        chk("bp_regrant_y", 32'(y), 32'h9);

        // Fairness under continuous load.
        do_reset();
        drive(1'b1, 4'hF, 16'hDCBA, 1'b1);
        step();
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        repeats = 0;
        grants = 0;
        prev = 2'd3;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) begin
                grants++;
                cnt[sel]++;
                if (grants > 1 && sel == prev) repeats++;
                prev = sel;
            end
        end
        chk("fair_grants", 32'(grants), 32'd40);
        chk("fair_repeats", 32'(repeats), 32'd0);
        for (int c = 0; c < 4; c++) chk($sformatf("fair_cnt%0d", c), 32'(cnt[c]), 32'd10);

        // Reset while a grant is being accepted and three channels are full.
        do_reset();
        drive(1'b1, 4'h7, 16'h0876, 1'b1);
        step();
        in_valid = 4'h0;
        step();
        chk("mid_pre_ov", 32'(out_valid), 32'd1);
        chk("mid_pre_full", 32'(in_ready), 32'h8);
        rst = 1'b0;
        step();
        chk("mid_in_ready", 32'(in_ready), 32'hF);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_sel", 32'(sel), 32'd0);
        chk("mid_d", 32'({d3, d2, d1, d0}), 32'h0);
`ifdef MUX_RR_FEED_CNT_EN
        chk("mid_acc_cnt", 32'(acc_cnt), 32'd0);

        // Counter wrap after 65537 accepted words.
        do_reset();
        drive(1'b1, 4'hF, 16'h1234, 1'b1);
        begin
            int exp_cnt;
            int budget;
            exp_cnt = 0;
            budget = 0;
            while (exp_cnt < 65537 && budget < 70000) begin
                if (out_valid && out_ready) exp_cnt++;
                step();
                budget++;
            end
            chk("wrap_budget", 32'(exp_cnt), 32'd65537);
            chk("wrap_acc_cnt", 32'(acc_cnt), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_4_1_rr_feeder.md
# mux_4_1_rr_feeder

Four-channel round-robin feeder that sits directly upstream of the 4:1 combinational mux stage. Each channel gets a one-word holding register with a valid/ready input handshake. The block drives the mux data inputs `d0`..`d3` from those registers and a registered `sel` pointing at the granted channel. A single `out_valid`/`out_ready` handshake covers the muxed result `y`, which the consumer takes from the mux.

## Interface
- `W`, default 4: data width per channel; must match the mux data width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low. Sampled only on `clk`.
- `in_valid`  in  4: per-channel word valid; bit i belongs to channel i.
- `in_ready`  out  4: per-channel ready; `in_ready[i] = !full[i]`, combinational from the register only.
- `in_data0`..`in_data3`  in  W each: channel words.
- `d0`..`d3`  out  W each: holding registers, wired straight to the mux `d` inputs.
- `sel`  out  2: registered grant index, wired to the mux `sel`.
- `out_valid`  out  1: `y` holds a granted word.
- `out_ready`  in  1: consumer accepts `y` when `out_valid && out_ready`.
- `acc_cnt`  out  16: present only with `MUX_RR_FEED_CNT_EN`.

## Operation
- **State:** `full[3:0]`, `d0..d3`, `sel`, `out_valid` and `last[1:0]` (the last granted channel).
- **Reset** (`rst == 0` at an edge):
  - `full = 0`, `d0..d3 = 0`, `sel = 0`, `out_valid = 0`, `last = 3`.
  - `last = 3` makes the first search start at channel 0.
  - Reset overrides every other event in that cycle, including a pending acceptance or capture. Words held at that point are dropped.
- **Capture:** when `in_valid[i] && in_ready[i]`, then `d_i <= in_data_i` and `full[i] <= 1`.
  - `d_i` is written only on capture and is otherwise held.
- **Drain:** when `out_valid && out_ready`, then `full[sel] <= 0`.
- **Slot free:** `free = !out_valid || out_ready`.
- **Arbitration** (only when `free`):
  - Candidates are `full` with bit `sel` masked off if the current grant is being drained this cycle.
  - Search order: `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - First hit: `sel <= hit`, `last <= hit`, `out_valid <= 1`.
  - No hit: `out_valid <= 0`; `sel` and `last` hold.
  - Words captured at the same edge are not candidates; they become eligible at the next edge.
- **Stall:** when `out_valid && !out_ready`, then `sel`, `last`, `out_valid` and `d[sel]` hold. `y` is therefore stable until accepted.
- **Overwrite protection:** a granted channel cannot be overwritten, because `full[sel]` stays 1 until drain and that holds its `in_ready` low.
- **Same-edge capture on the drained channel:** impossible, because `in_ready` was 0 during that cycle.
- **Simultaneous events:** a capture on one channel, a drain of another and a new grant may all occur at one edge. They are independent.

## Timing
- **Capture to `out_valid`:** 1 cycle when idle. A word captured at edge N gives `out_valid = 1` after edge N+1.
- **Throughput:** one word per cycle while `out_ready = 1` and at least two channels are full.
- **Single active channel:** one word per 3 cycles (capture, grant, drain/refill).
- **Fairness:** every full channel is granted within 4 grants.
- **Combinational paths:** none from inputs to outputs. `in_ready` depends only on `full`.

## Configuration
- **`MUX_RR_FEED_CNT_EN` defined:**
  - Adds output `acc_cnt[15:0]`.
  - Reset value 0.
  - Increments by 1 on every `out_valid && out_ready` edge.
  - Wraps 0xFFFF to 0x0000.
  - Reset has priority over increment.
- **Not defined:**
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold `rst = 0` for 2 cycles with `in_valid = 4'hF` → `in_ready = 4'hF`, `out_valid = 0`, `sel = 0`, `d0..d3 = 0`. Release, then pulse channel 2 with `in_data2 = 4'hA` → `out_valid = 1`, `sel = 2`, `d2 = 4'hA` one cycle after capture.
- **Round-robin order:** fill all four channels with 1, 2, 3, 4 in one cycle and hold `out_ready = 1` → grants `sel` = 0, 1, 2, 3 on consecutive cycles, mux `y` = 1, 2, 3, 4, then `out_valid = 0`.
- **Backpressure:** channel 1 granted with `4'h5` and `out_ready = 0` for 5 cycles while channel 1 keeps `in_valid` with `4'h9` → `sel = 1`, `d1 = 4'h5`, `in_ready[1] = 0` throughout. On release, `y = 5` is accepted and `4'h9` is captured the next cycle.
- **Fairness under load:** all channels continuously valid, `out_ready = 1` for 40 cycles → each channel granted exactly 10 times, never twice in a row.
- **Reset mid-operation:** assert `rst = 0` while `out_valid = 1` and `out_ready = 1` with 3 channels full → next cycle all outputs at reset values. With `MUX_RR_FEED_CNT_EN`, `acc_cnt = 0`.
- **Counter wrap** (`MUX_RR_FEED_CNT_EN`): 65537 accepted words → `acc_cnt = 1`.
